decode_execute_pipe: RTL and testbench

DECODE_EXECUTE_PIPE -- requirements
Module: decode_execute_pipe

---
 rtl/decode_execute_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_decode_execute_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute pipeline for the RV32 R/I integer ALU subset.
// D holds the decoded instruction; X holds the registered result and drives out_*.
module decode_execute_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int IMM_EN = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [AW-1:0]   out_rd,
    output logic            out_illegal
);

    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } alu_op_e;

    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx >> AW) == 5'd0;
    endfunction

    function automatic logic [XLEN-1:0] alu(input alu_op_e op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SW-1:0]          sh;
        logic [XLEN-1:0]        r;
        sa = signed'(a);
        sb = signed'(b);
        sh = b[SW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = unsigned'(sa >>> sh);
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = in_instr[6:0];
    assign rd_f   = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    alu_op_e         dec_op;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_op      = OP_ADD;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b1;
        dec_imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        if (opcode == OPC_R) begin
            dec_illegal = 1'b0;
            if (funct7 == 7'b0000000) begin
                case (funct3)
                    3'd0: dec_op = OP_ADD;
                    3'd1: dec_op = OP_SLL;
                    3'd2: dec_op = OP_SLT;
                    3'd3: dec_op = OP_SLTU;
                    3'd4: dec_op = OP_XOR;
                    3'd5: dec_op = OP_SRL;
                    3'd6: dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                dec_op = OP_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                dec_op = OP_SRA;
            end else begin
                dec_illegal = 1'b1;
            end
            if (!idx_ok(rs2_f)) dec_illegal = 1'b1;
        end else if (opcode == OPC_I && IMM_EN != 0) begin
            dec_use_imm = 1'b1;
            dec_illegal = 1'b0;
            case (funct3)
                3'd0: dec_op = OP_ADD;
                3'd2: dec_op = OP_SLT;
                3'd3: dec_op = OP_SLTU;
                3'd4: dec_op = OP_XOR;
                3'd6: dec_op = OP_OR;
                3'd7: dec_op = OP_AND;
                3'd1: begin
                    dec_op = OP_SLL;
                    if (in_instr[31:26] != 6'b000000) dec_illegal = 1'b1;
                end
                default: begin
                    if (in_instr[31:26] == 6'b000000) begin
                        dec_op = OP_SRL;
                    end else if (in_instr[31:26] == 6'b010000) begin
                        dec_op = OP_SRA;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
            endcase
            // RV32 has only 5-bit shift amounts; bit 25 set is reserved.
            if ((funct3 == 3'd1 || funct3 == 3'd5) && XLEN == 32 && in_instr[25])
                dec_illegal = 1'b1;
        end
        if (!idx_ok(rd_f) || !idx_ok(rs1_f)) dec_illegal = 1'b1;
    end

    logic            d_valid_q, d_valid_d;
    alu_op_e         d_op_q, d_op_d;
    logic            d_use_imm_q, d_use_imm_d;
    logic            d_illegal_q, d_illegal_d;
    logic [XLEN-1:0] d_imm_q, d_imm_d;
    logic [AW-1:0]   d_rd_q, d_rd_d;
    logic [AW-1:0]   d_rs1_q, d_rs1_d;
    logic [AW-1:0]   d_rs2_q, d_rs2_d;

    logic            x_valid_q, x_valid_d;
    logic [XLEN-1:0] x_result_q, x_result_d;
    logic [AW-1:0]   x_rd_q, x_rd_d;
    logic            x_illegal_q, x_illegal_d;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    logic            x_adv;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;

    assign x_adv    = d_valid_q & (~x_valid_q | out_ready);
    assign in_ready = ~d_valid_q | x_adv;
    assign accept   = in_valid & in_ready;

    // Register read happens as D hands over to X, so every older write has already landed.
    assign rs1_val = (d_rs1_q == '0) ? '0 : rf_q[d_rs1_q];
    assign rs2_val = (d_rs2_q == '0) ? '0 : rf_q[d_rs2_q];
    assign op_b    = d_use_imm_q ? d_imm_q : rs2_val;
    assign alu_res = alu(d_op_q, rs1_val, op_b);

    always_comb begin
        d_valid_d   = d_valid_q;
        d_op_d      = d_op_q;
        d_use_imm_d = d_use_imm_q;
        d_illegal_d = d_illegal_q;
        d_imm_d     = d_imm_q;
        d_rd_d      = d_rd_q;
        d_rs1_d     = d_rs1_q;
        d_rs2_d     = d_rs2_q;
        if (accept) begin
            d_valid_d   = 1'b1;
            d_op_d      = dec_op;
            d_use_imm_d = dec_use_imm;
            d_illegal_d = dec_illegal;
            d_imm_d     = dec_imm;
            d_rd_d      = rd_f[AW-1:0];
            d_rs1_d     = rs1_f[AW-1:0];
            d_rs2_d     = rs2_f[AW-1:0];
        end else if (x_adv) begin
            d_valid_d = 1'b0;
        end
    end

    always_comb begin
        x_valid_d   = x_valid_q;
        x_result_d  = x_result_q;
        x_rd_d      = x_rd_q;
        x_illegal_d = x_illegal_q;
        rf_d        = rf_q;
        if (x_adv) begin
            x_valid_d   = 1'b1;
            x_result_d  = d_illegal_q ? '0 : alu_res;
            x_rd_d      = d_rd_q;
            x_illegal_d = d_illegal_q;
            if (!d_illegal_q && d_rd_q != '0) rf_d[d_rd_q] = alu_res;
        end else if (out_ready) begin
            x_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid_q   <= 1'b0;
            d_op_q      <= OP_ADD;
            d_use_imm_q <= 1'b0;
            d_illegal_q <= 1'b0;
            d_imm_q     <= '0;
            d_rd_q      <= '0;
            d_rs1_q     <= '0;
            d_rs2_q     <= '0;
            x_valid_q   <= 1'b0;
            x_result_q  <= '0;
            x_rd_q      <= '0;
            x_illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_op_q      <= d_op_d;
            d_use_imm_q <= d_use_imm_d;
            d_illegal_q <= d_illegal_d;
            d_imm_q     <= d_imm_d;
            d_rd_q      <= d_rd_d;
            d_rs1_q     <= d_rs1_d;
            d_rs2_q     <= d_rs2_d;
            x_valid_q   <= x_valid_d;
            x_result_q  <= x_result_d;
            x_rd_q      <= x_rd_d;
            x_illegal_q <= x_illegal_d;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign out_valid   = x_valid_q;
    assign out_result  = x_result_q;
    assign out_rd      = x_rd_q;
    assign out_illegal = x_illegal_q;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Scoreboard bench: the driver executes each accepted instruction on an
// architectural register model; an independent monitor checks the DUT output stream.
module tb_decode_execute_pipe;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int IMM_EN = 1;
    localparam int AW     = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [AW-1:0]   out_rd;
    logic            out_illegal;

    always #5 clk = ~clk;

    decode_execute_pipe #(.XLEN(XLEN), .NREGS(NREGS), .IMM_EN(IMM_EN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_q[$];
    logic [31:0] mregs[32];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    bit lat_chk   = 0;
    bit rand_rdy  = 0;
    bit rdy_fixed = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_q.delete();
    endtask

    // Architectural semantics of the R/I subset on a 32-entry register file.
    task automatic model_accept(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] r;
        logic        ill;
        opc = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        f7  = ins[31:25];
        a   = mregs[ins[19:15]];
        b   = mregs[ins[24:20]];
        imm = {{20{ins[31]}}, ins[31:20]};
        ill = 1'b1;
        r   = 32'h0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                ill = 1'b0;
                case (f3)
                    3'd0: r = a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: r = a >> b[4:0];
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                ill = 1'b0; r = a - b;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                ill = 1'b0; r = $signed(a) >>> b[4:0];
            end
        end else if (opc == 7'h13 && IMM_EN != 0) begin
            case (f3)
                3'd0: begin ill = 1'b0; r = a + imm; end
                3'd2: begin ill = 1'b0; r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
                3'd3: begin ill = 1'b0; r = (a < imm) ? 32'd1 : 32'd0; end
                3'd4: begin ill = 1'b0; r = a ^ imm; end
                3'd6: begin ill = 1'b0; r = a | imm; end
                3'd7: begin ill = 1'b0; r = a & imm; end
                3'd1: if (f7 == 7'h00) begin ill = 1'b0; r = a << ins[24:20]; end
                default: begin
                    if (f7 == 7'h00) begin ill = 1'b0; r = a >> ins[24:20]; end
                    else if (f7 == 7'h20) begin ill = 1'b0; r = $signed(a) >>> ins[24:20]; end
                end
            endcase
        end
        if (ill) r = 32'h0;
        else if (rd != 5'd0) mregs[rd] = r;
        e.res = r; e.rd = rd; e.ill = ill; e.acc = cyc; e.lat = lat_chk;
        exp_q.push_back(e);
    endtask

    // Driver: offers the head of stim_q; acceptance decided at the falling edge.
    initial begin
        in_valid = 1'b0;
        in_instr = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && stim_q.size() > 0 && !(rand_rdy && $urandom_range(0, 4) == 0)) begin
                in_valid = 1'b1;
                in_instr = stim_q[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready && rst_n) begin
                model_accept(stim_q.pop_front());
                n_acc++;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    // Monitor: scoreboard pop on each transfer, plus hold-stability while stalled.
    initial begin
        exp_t        e;
        bit          hold_v;
        logic [31:0] hold_res;
        logic [4:0]  hold_rd;
        logic        hold_ill;
        hold_v = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_result", 64'(out_result), 64'(hold_res));
                    check("hold_rd", 64'(out_rd), 64'(hold_rd));
                    check("hold_illegal", 64'(out_illegal), 64'(hold_ill));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: got result %0h want no output", out_result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'(out_result), 64'(e.res));
                        check("rd", 64'(out_rd), 64'(e.rd));
                        check("illegal", 64'(out_illegal), 64'(e.ill));
                        if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
                    end
                end
                hold_v   = out_valid && !out_ready;
                hold_res = out_result;
                hold_rd  = out_rd;
                hold_ill = out_illegal;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(stim_q.size() + exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        k   = $urandom_range(0, 9);
        f3  = 3'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        if (k <= 3) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return r_ins(f7, rs2, rs1, f3, rd);
        end else if (k <= 6) begin
            if (f3 == 3'd1) return i_ins({7'h00, rs2}, rs1, f3, rd);
            if (f3 == 3'd5) return i_ins({($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2}, rs1, f3, rd);
            return i_ins(12'($urandom), rs1, f3, rd);
        end else if (k == 7) begin
            return r_ins(7'($urandom), rs2, rs1, f3, rd);
        end else if (k == 8) begin
            return $urandom;
        end
        return i_ins({($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00, 1'b1, rs2}, rs1,
                     ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5, rd);
    endfunction

    initial begin
        int          base;
        logic [31:0] held;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);

        // Back-to-back dependent adds, exact latency enforced.
        lat_chk = 1;
        stim_q.push_back(i_ins(12'd5, 5'd0, 3'd0, 5'd1));
        stim_q.push_back(i_ins(12'd7, 5'd0, 3'd0, 5'd2));
        stim_q.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        wait_drain(50);

        stim_q.push_back(i_ins(12'hFFF, 5'd0, 3'd0, 5'd1));
        stim_q.push_back(r_ins(7'h00, 5'd1, 5'd0, 3'd3, 5'd2));
        stim_q.push_back(r_ins(7'h00, 5'd1, 5'd0, 3'd2, 5'd3));
        stim_q.push_back(i_ins(12'd9, 5'd0, 3'd0, 5'd0));
        stim_q.push_back(r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd4));
        wait_drain(50);

        stim_q.push_back(r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));
        stim_q.push_back(i_ins(12'h021, 5'd1, 3'd1, 5'd2));
        stim_q.push_back(r_ins(7'h00, 5'd0, 5'd3, 3'd0, 5'd11));
        stim_q.push_back(r_ins(7'h00, 5'd0, 5'd2, 3'd0, 5'd12));
        stim_q.push_back(r_ins(7'h20, 5'd1, 5'd0, 3'd5, 5'd13));
        stim_q.push_back(i_ins(12'h7FF, 5'd1, 3'd4, 5'd14));
        wait_drain(50);

        // Backpressure: three offered while the consumer stalls.
        lat_chk   = 0;
        rdy_fixed = 0;
        base = n_acc;
        stim_q.push_back(i_ins(12'd11, 5'd0, 3'd0, 5'd8));
        stim_q.push_back(i_ins(12'd22, 5'd0, 3'd0, 5'd9));
        stim_q.push_back(r_ins(7'h00, 5'd9, 5'd8, 3'd0, 5'd10));
        repeat (3) @(negedge clk);
        held = out_result;
        repeat (2) @(negedge clk);
        check("stall_accepted", 64'(n_acc - base), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_result_stable", 64'(out_result), 64'(held));
        rdy_fixed = 1;
        wait_drain(50);

        // Reset with two instructions in flight.
        rdy_fixed = 0;
        base = n_acc;
        stim_q.push_back(i_ins(12'd3, 5'd0, 3'd0, 5'd1));
        stim_q.push_back(i_ins(12'd4, 5'd0, 3'd0, 5'd2));
        repeat (3) @(negedge clk);
        check("inflight_accepted", 64'(n_acc - base), 64'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rdy_fixed = 1;
        for (int i = 0; i < 4; i++) begin
            check("post_reset_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        lat_chk = 1;
        stim_q.push_back(r_ins(7'h00, 5'd0, 5'd1, 3'd0, 5'd5));
        stim_q.push_back(r_ins(7'h00, 5'd0, 5'd2, 3'd0, 5'd6));
        wait_drain(50);

        // Randomised traffic with random backpressure and input bubbles.
        lat_chk  = 0;
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) stim_q.push_back(rand_instr());
        wait_drain(4000);
        rand_rdy = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
